// File: rtl/io_pkg.sv
// Shared definitions for the CPU-to-peripheral IO bridge: address map,
// bridge states, device select codes and the byte-merge helper.
package io_pkg;

    localparam logic [31:0] TMR_BASE   = 32'h0000_7F00;
    localparam logic [31:0] TMR_LIMIT  = 32'h0000_7F0B;
    localparam logic [31:0] SW_BASE    = 32'h0000_7F2C;
    localparam logic [31:0] SW_LIMIT   = 32'h0000_7F33;
    localparam logic [31:0] LED_BASE   = 32'h0000_7F34;
    localparam logic [31:0] LED_LIMIT  = 32'h0000_7F37;
    localparam logic [31:0] TUBE_BASE  = 32'h0000_7F38;
    localparam logic [31:0] TUBE_LIMIT = 32'h0000_7F3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } io_state_e;

    typedef enum logic [2:0] {
        DEV_NONE = 3'd0,
        DEV_TMR  = 3'd1,
        DEV_SW   = 3'd2,
        DEV_LED  = 3'd3,
        DEV_TUBE = 3'd4
    } dev_sel_e;

    // Enabled bytes come from new_data, the rest keep old_data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Combinational address decoder: byte address -> device select, read-only
// and mapped flags. Ranges are word aligned, so addr[1:0] never changes the result.
module io_addr_decode
    import io_pkg::*;
(
    input  logic [31:0] addr,
    output dev_sel_e    dev_sel,
    output logic        read_only,
    output logic        mapped
);

    always_comb begin
        dev_sel   = DEV_NONE;
        read_only = 1'b0;
        if (addr >= TMR_BASE && addr <= TMR_LIMIT) begin
            dev_sel = DEV_TMR;
        end else if (addr >= SW_BASE && addr <= SW_LIMIT) begin
            dev_sel   = DEV_SW;
            read_only = 1'b1;
        end else if (addr >= LED_BASE && addr <= LED_LIMIT) begin
            dev_sel = DEV_LED;
        end else if (addr >= TUBE_BASE && addr <= TUBE_LIMIT) begin
            dev_sel = DEV_TUBE;
        end
        mapped = (dev_sel != DEV_NONE);
    end

endmodule

// File: rtl/io_bridge.sv
// Single-outstanding CPU-to-peripheral bridge. Reads and partial writes
// fetch the device word in READ; writes strobe one device WE in WRITE.
module io_bridge
    import io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic [29:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic        tmr_we,
    output logic        led_we,
    output logic        tube_we,
    input  logic [31:0] tmr_rdata,
    input  logic [31:0] sw_rdata,
    input  logic [31:0] led_rdata,
    input  logic [31:0] tube_rdata,
    output io_state_e   state_dbg
);

    // Handshake: cpu_req is a level sampled only in IDLE (the acceptance edge);
    // the access completes with a one-cycle cpu_ready pulse in RESP, during
    // which cpu_rdata and cpu_err are valid. Requests outside IDLE are ignored.

    io_state_e   state, state_next;
    dev_sel_e    dec_sel, sel_q;
    logic        dec_ro, dec_mapped;
    logic        acc_err, acc_nop;
    logic        we_q, err_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, dev_rdata;
    logic        wr_cycle;

    io_addr_decode u_decode (
        .addr      (cpu_addr),
        .dev_sel   (dec_sel),
        .read_only (dec_ro),
        .mapped    (dec_mapped)
    );

    always_comb begin
        acc_err = !dec_mapped || (cpu_we && dec_ro);
        acc_nop = cpu_we && (cpu_be == 4'h0);
    end

    always_comb begin
        dev_rdata = 32'h0;
        case (sel_q)
            DEV_TMR:  dev_rdata = tmr_rdata;
            DEV_SW:   dev_rdata = sw_rdata;
            DEV_LED:  dev_rdata = led_rdata;
            DEV_TUBE: dev_rdata = tube_rdata;
            default:  dev_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (acc_err || acc_nop)                 state_next = ST_RESP;
                    else if (!cpu_we || cpu_be != 4'hF)     state_next = ST_READ;
                    else                                    state_next = ST_WRITE;
                end
            end
            ST_READ:  state_next = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dev_addr  <= '0;
            dev_wdata <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            err_q     <= 1'b0;
            sel_q     <= DEV_NONE;
            rdata_q   <= '0;
        end else if (state == ST_IDLE && cpu_req) begin
            dev_addr  <= cpu_addr[31:2];
            dev_wdata <= cpu_wdata;
            we_q      <= cpu_we;
            be_q      <= cpu_be;
            err_q     <= acc_err;
            sel_q     <= acc_err ? DEV_NONE : dec_sel;
            // A failed read still completes a read, so it clears the held data.
            if (!cpu_we && acc_err) rdata_q <= '0;
        end else if (state == ST_READ) begin
            if (we_q) dev_wdata <= merge_bytes(dev_rdata, dev_wdata, be_q);
            else      rdata_q   <= dev_rdata;
        end
    end

    // Reset is gated in so a mid-access reset suppresses strobes in that very cycle.
    always_comb begin
        wr_cycle  = (state == ST_WRITE) && !reset;
        tmr_we    = wr_cycle && (sel_q == DEV_TMR);
        led_we    = wr_cycle && (sel_q == DEV_LED);
        tube_we   = wr_cycle && (sel_q == DEV_TUBE);
        cpu_ready = (state == ST_RESP) && !reset;
        cpu_err   = cpu_ready && err_q;
        cpu_rdata = (cpu_ready && we_q) ? 32'h0 : rdata_q;
        state_dbg = state;
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: latency, strobes, merge, errors, reset and
// back-to-back behaviour against hand-computed expectations.
module tb_io_bridge;
    import io_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic [29:0] dev_addr;
    logic [31:0] dev_wdata;
    logic        tmr_we, led_we, tube_we;
    logic [31:0] tmr_rdata, sw_rdata, led_rdata, tube_rdata;
    io_state_e   state_dbg;

    int n_vec  = 0;
    int n_miss = 0;

    int          obs_lat, obs_n_tmr, obs_n_led, obs_n_tube, obs_n_ready;
    logic        obs_err, obs_overlap;
    logic [31:0] obs_rdata, obs_wdata;
    logic [29:0] obs_dev_addr;

    always #5 clk = ~clk;

    io_bridge dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .tmr_we(tmr_we), .led_we(led_we), .tube_we(tube_we),
        .tmr_rdata(tmr_rdata), .sw_rdata(sw_rdata), .led_rdata(led_rdata),
        .tube_rdata(tube_rdata), .state_dbg(state_dbg)
    );

    // One access from IDLE; obs_lat = negedges after the acceptance edge until ready.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
        obs_lat = 99; obs_rdata = 32'hDEAD_BEEF; obs_err = 1'bx; obs_wdata = 32'h0;
        obs_n_tmr = 0; obs_n_led = 0; obs_n_tube = 0; obs_overlap = 1'b0;
        obs_dev_addr = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (int'(tmr_we) + int'(led_we) + int'(tube_we) > 1) obs_overlap = 1'b1;
            if (tmr_we)  obs_n_tmr++;
            if (led_we)  obs_n_led++;
            if (tube_we) obs_n_tube++;
            if (tmr_we || led_we || tube_we) begin
                obs_wdata = dev_wdata;
                obs_dev_addr = dev_addr;
            end
            if (cpu_ready) begin
                obs_lat = k; obs_rdata = cpu_rdata; obs_err = cpu_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (cpu_rdata !== 32'h0) begin n_miss++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
        n_vec++; if (cpu_ready !== 1'b0) begin n_miss++; $display("FAIL reset_ready got=%b exp=0", cpu_ready); end
        n_vec++; if (cpu_err !== 1'b0) begin n_miss++; $display("FAIL reset_err got=%b exp=0", cpu_err); end
        n_vec++; if (dev_addr !== 30'h0) begin n_miss++; $display("FAIL reset_dev_addr got=%h exp=0", dev_addr); end
        n_vec++; if (dev_wdata !== 32'h0) begin n_miss++; $display("FAIL reset_dev_wdata got=%h exp=0", dev_wdata); end
        n_vec++; if ({tmr_we, led_we, tube_we} !== 3'b000) begin n_miss++; $display("FAIL reset_we got=%b exp=000", {tmr_we, led_we, tube_we}); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (state_dbg !== ST_IDLE) begin n_miss++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_full_write;
        do_access(1'b1, 32'h7F38, 4'hF, 32'h1234_5678);
        n_vec++; if (obs_lat !== 2) begin n_miss++; $display("FAIL fw_latency got=%0d exp=2", obs_lat); end
        n_vec++; if (obs_n_tube !== 1) begin n_miss++; $display("FAIL fw_tube_we_cycles got=%0d exp=1", obs_n_tube); end
        n_vec++; if (obs_n_tmr + obs_n_led !== 0) begin n_miss++; $display("FAIL fw_other_we got=%0d exp=0", obs_n_tmr + obs_n_led); end
        n_vec++; if (obs_wdata !== 32'h1234_5678) begin n_miss++; $display("FAIL fw_dev_wdata got=%h exp=12345678", obs_wdata); end
        n_vec++; if (obs_dev_addr !== 30'h1FCE) begin n_miss++; $display("FAIL fw_dev_addr got=%h exp=1fce", obs_dev_addr); end
        n_vec++; if (obs_err !== 1'b0) begin n_miss++; $display("FAIL fw_err got=%b exp=0", obs_err); end
        n_vec++; if (obs_rdata !== 32'h0) begin n_miss++; $display("FAIL fw_rdata got=%h exp=0", obs_rdata); end
        do_access(1'b1, 32'h7F08, 4'hF, 32'hCAFE_0001);
        n_vec++; if (obs_n_tmr !== 1 || obs_n_tube !== 0 || obs_n_led !== 0) begin n_miss++; $display("FAIL fw_timer_we got=%0d/%0d/%0d exp=1/0/0", obs_n_tmr, obs_n_led, obs_n_tube); end
        n_vec++; if (obs_wdata !== 32'hCAFE_0001) begin n_miss++; $display("FAIL fw_timer_wdata got=%h exp=cafe0001", obs_wdata); end
    endtask

    task automatic test_partial_write;
        tube_rdata = 32'hAABB_CCDD;
        do_access(1'b1, 32'h7F38, 4'b0010, 32'h0000_1100);
        n_vec++; if (obs_lat !== 3) begin n_miss++; $display("FAIL pw_latency got=%0d exp=3", obs_lat); end
        n_vec++; if (obs_n_tube !== 1) begin n_miss++; $display("FAIL pw_tube_we_cycles got=%0d exp=1", obs_n_tube); end
        n_vec++; if (obs_wdata !== 32'hAABB_11DD) begin n_miss++; $display("FAIL pw_merge got=%h exp=aabb11dd", obs_wdata); end
        n_vec++; if (obs_err !== 1'b0) begin n_miss++; $display("FAIL pw_err got=%b exp=0", obs_err); end
        tmr_rdata = 32'h1122_3344;
        do_access(1'b1, 32'h7F04, 4'b1001, 32'hAABB_CCDD);
        n_vec++; if (obs_wdata !== 32'hAA22_33DD) begin n_miss++; $display("FAIL pw_merge_1001 got=%h exp=aa2233dd", obs_wdata); end
        n_vec++; if (obs_n_tmr !== 1 || obs_lat !== 3) begin n_miss++; $display("FAIL pw_timer got=we%0d lat%0d exp=we1 lat3", obs_n_tmr, obs_lat); end
    endtask

    task automatic test_switch;
        sw_rdata = 32'h0000_005A;
        do_access(1'b0, 32'h7F2C, 4'h0, 32'h0);
        n_vec++; if (obs_rdata !== 32'h5A) begin n_miss++; $display("FAIL sw_read_data got=%h exp=5a", obs_rdata); end
        n_vec++; if (obs_lat !== 2) begin n_miss++; $display("FAIL sw_read_latency got=%0d exp=2", obs_lat); end
        n_vec++; if (obs_err !== 1'b0) begin n_miss++; $display("FAIL sw_read_err got=%b exp=0", obs_err); end
        @(negedge clk);
        n_vec++; if (cpu_rdata !== 32'h5A) begin n_miss++; $display("FAIL sw_rdata_hold got=%h exp=5a", cpu_rdata); end
        do_access(1'b1, 32'h7F30, 4'hF, 32'hFFFF_FFFF);
        n_vec++; if (obs_err !== 1'b1) begin n_miss++; $display("FAIL sw_write_err got=%b exp=1", obs_err); end
        n_vec++; if (obs_lat !== 1) begin n_miss++; $display("FAIL sw_write_latency got=%0d exp=1", obs_lat); end
        n_vec++; if (obs_n_tmr + obs_n_led + obs_n_tube !== 0) begin n_miss++; $display("FAIL sw_write_we got=%0d exp=0", obs_n_tmr + obs_n_led + obs_n_tube); end
        n_vec++; if (obs_rdata !== 32'h0) begin n_miss++; $display("FAIL sw_write_rdata got=%h exp=0", obs_rdata); end
        @(negedge clk);
        n_vec++; if (cpu_rdata !== 32'h5A) begin n_miss++; $display("FAIL sw_rdata_hold2 got=%h exp=5a", cpu_rdata); end
        do_access(1'b0, 32'h7F33, 4'h0, 32'h0);
        n_vec++; if (obs_rdata !== 32'h5A || obs_err !== 1'b0) begin n_miss++; $display("FAIL sw_top_byte got=%h/%b exp=5a/0", obs_rdata, obs_err); end
    endtask

    task automatic test_unmapped;
        do_access(1'b0, 32'h7F40, 4'h0, 32'h0);
        n_vec++; if (obs_err !== 1'b1) begin n_miss++; $display("FAIL unm_7f40_err got=%b exp=1", obs_err); end
        n_vec++; if (obs_rdata !== 32'h0) begin n_miss++; $display("FAIL unm_7f40_rdata got=%h exp=0", obs_rdata); end
        n_vec++; if (obs_lat !== 1) begin n_miss++; $display("FAIL unm_7f40_latency got=%0d exp=1", obs_lat); end
        do_access(1'b0, 32'h7F0C, 4'h0, 32'h0);
        n_vec++; if (obs_err !== 1'b1) begin n_miss++; $display("FAIL unm_7f0c_err got=%b exp=1", obs_err); end
        do_access(1'b0, 32'h7F2B, 4'h0, 32'h0);
        n_vec++; if (obs_err !== 1'b1) begin n_miss++; $display("FAIL unm_7f2b_err got=%b exp=1", obs_err); end
        do_access(1'b1, 32'h7F34, 4'h0, 32'hFFFF_FFFF);
        n_vec++; if (obs_err !== 1'b0) begin n_miss++; $display("FAIL be0_err got=%b exp=0", obs_err); end
        n_vec++; if (obs_n_led !== 0) begin n_miss++; $display("FAIL be0_led_we got=%0d exp=0", obs_n_led); end
        n_vec++; if (obs_lat !== 1) begin n_miss++; $display("FAIL be0_latency got=%0d exp=1", obs_lat); end
    endtask

    task automatic test_reads;
        tmr_rdata = 32'h0000_1234; led_rdata = 32'h0000_00C3; tube_rdata = 32'h0F0F_0F0F;
        do_access(1'b0, 32'h7F0A, 4'h0, 32'h0);
        n_vec++; if (obs_rdata !== 32'h1234) begin n_miss++; $display("FAIL rd_timer got=%h exp=1234", obs_rdata); end
        do_access(1'b0, 32'h7F34, 4'h0, 32'h0);
        n_vec++; if (obs_rdata !== 32'hC3) begin n_miss++; $display("FAIL rd_led got=%h exp=c3", obs_rdata); end
        do_access(1'b0, 32'h7F3F, 4'h0, 32'h0);
        n_vec++; if (obs_rdata !== 32'h0F0F_0F0F || obs_lat !== 2) begin n_miss++; $display("FAIL rd_tube got=%h lat%0d exp=0f0f0f0f lat2", obs_rdata, obs_lat); end
    endtask

    task automatic test_reset_mid_access;
        int n_rdy, n_we;
        n_rdy = 0; n_we = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F38; cpu_be = 4'hF; cpu_wdata = 32'h5555_AAAA;
        @(negedge clk);
        cpu_req = 1'b0;
        reset = 1'b1;
        #1;
        n_vec++; if (tube_we !== 1'b0) begin n_miss++; $display("FAIL rst_mid_we got=%b exp=0", tube_we); end
        n_vec++; if (cpu_ready !== 1'b0) begin n_miss++; $display("FAIL rst_mid_ready got=%b exp=0", cpu_ready); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_ready) n_rdy++;
            if (tmr_we || led_we || tube_we) n_we++;
        end
        n_vec++; if (n_rdy !== 0 || n_we !== 0) begin n_miss++; $display("FAIL rst_mid_after got=rdy%0d we%0d exp=0/0", n_rdy, n_we); end
        led_rdata = 32'h0000_00C3;
        do_access(1'b0, 32'h7F34, 4'h0, 32'h0);
        n_vec++; if (obs_rdata !== 32'hC3 || obs_lat !== 2) begin n_miss++; $display("FAIL rst_mid_next got=%h lat%0d exp=c3 lat2", obs_rdata, obs_lat); end
    endtask

    task automatic test_back_to_back;
        int n_rdy, n_we;
        logic ovl;
        n_rdy = 0; n_we = 0; ovl = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F34; cpu_be = 4'hF; cpu_wdata = 32'h0000_0005;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cpu_ready) n_rdy++;
            if (led_we) n_we++;
            if (int'(tmr_we) + int'(led_we) + int'(tube_we) > 1) ovl = 1'b1;
        end
        cpu_req = 1'b0;
        n_vec++; if (n_rdy !== 4) begin n_miss++; $display("FAIL b2b_ready_count got=%0d exp=4", n_rdy); end
        n_vec++; if (n_we !== 4) begin n_miss++; $display("FAIL b2b_we_count got=%0d exp=4", n_we); end
        n_vec++; if (ovl !== 1'b0) begin n_miss++; $display("FAIL b2b_overlap got=%b exp=0", ovl); end
        @(negedge clk);
        n_vec++; if (cpu_ready !== 1'b0 || led_we !== 1'b0) begin n_miss++; $display("FAIL b2b_quiet got=%b%b exp=00", cpu_ready, led_we); end
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        tmr_rdata = '0; sw_rdata = '0; led_rdata = '0; tube_rdata = '0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_switch();
        test_unmapped();
        test_reads();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
